tlb: RTL and testbench

- Fully associative LoongArch TLB array; it is the responder at the other end of the WB-stage TLB write/read interface (tlbwr, tlbfill, tlbrd).
- Provides two combinational lookup ports: s0 for IF fetch translation and s1 for MEM load/store and tlbsrch.
- Executes INVTLB invalidation operations.
- Entry state is held in registers; all updates commit on the clock edge.

---
 rtl/tlb.sv | 201 ++++++++++++++++++++
 tb/tb_tlb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tlb.sv
// rtl/tlb.sv - fully associative TLB array with two lookup ports, read/write port and INVTLB
// Only the E bits are reset; all other entry fields are plain data registers.
module tlb #(
   parameter int TLBNUM = 16,
   parameter int IDXW   = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [18:0]     s0_vppn,
   input  logic            s0_va_bit12,
   input  logic [9:0]      s0_asid,
   output logic            s0_found,
   output logic [IDXW-1:0] s0_index,
   output logic [19:0]     s0_ppn,
   output logic [5:0]      s0_ps,
   output logic [1:0]      s0_plv,
   output logic [1:0]      s0_mat,
   output logic            s0_d,
   output logic            s0_v,
   input  logic [18:0]     s1_vppn,
   input  logic            s1_va_bit12,
   input  logic [9:0]      s1_asid,
   output logic            s1_found,
   output logic [IDXW-1:0] s1_index,
   output logic [19:0]     s1_ppn,
   output logic [5:0]      s1_ps,
   output logic [1:0]      s1_plv,
   output logic [1:0]      s1_mat,
   output logic            s1_d,
   output logic            s1_v,
   input  logic            invtlb_valid,
   input  logic [4:0]      invtlb_op,
   input  logic [9:0]      invtlb_asid,
   input  logic [18:0]     invtlb_vppn,
   input  logic            we,
   input  logic [IDXW-1:0] w_index,
   input  logic            w_e,
   input  logic [18:0]     w_vppn,
   input  logic [5:0]      w_ps,
   input  logic [9:0]      w_asid,
   input  logic            w_g,
   input  logic [19:0]     w_ppn0,
   input  logic [1:0]      w_plv0,
   input  logic [1:0]      w_mat0,
   input  logic            w_d0,
   input  logic            w_v0,
   input  logic [19:0]     w_ppn1,
   input  logic [1:0]      w_plv1,
   input  logic [1:0]      w_mat1,
   input  logic            w_d1,
   input  logic            w_v1,
   input  logic [IDXW-1:0] r_index,
   output logic            r_e,
   output logic [18:0]     r_vppn,
   output logic [5:0]      r_ps,
   output logic [9:0]      r_asid,
   output logic            r_g,
   output logic [19:0]     r_ppn0,
   output logic [1:0]      r_plv0,
   output logic [1:0]      r_mat0,
   output logic            r_d0,
   output logic            r_v0,
   output logic [19:0]     r_ppn1,
   output logic [1:0]      r_plv1,
   output logic [1:0]      r_mat1,
   output logic            r_d1,
   output logic            r_v1
);

   typedef struct packed {
      logic [19:0] ppn;
      logic [1:0]  plv;
      logic [1:0]  mat;
      logic        d;
      logic        v;
   } page_t;

   typedef struct packed {
      logic            found;
      logic [IDXW-1:0] index;
      logic [5:0]      ps;
      page_t           pg;
   } res_t;

   logic [TLBNUM-1:0] e_q;
   logic [18:0]       vppn_q [TLBNUM];
   logic [5:0]        ps_q   [TLBNUM];
   logic [9:0]        asid_q [TLBNUM];
   logic              g_q    [TLBNUM];
   page_t             pg0_q  [TLBNUM];
   page_t             pg1_q  [TLBNUM];
   logic [TLBNUM-1:0] inv_hit;

   function automatic logic va_match(input logic [18:0] ev, input logic [5:0] ps,
                                     input logic [18:0] qv);
      if (ps == 6'd21) return ev[18:9] == qv[18:9];
      return ev == qv;
   endfunction

   logic [18:0] lk_vppn [2];
   logic        lk_b12  [2];
   logic [9:0]  lk_asid [2];

   assign lk_vppn[0] = s0_vppn;
   assign lk_vppn[1] = s1_vppn;
   assign lk_b12[0]  = s0_va_bit12;
   assign lk_b12[1]  = s1_va_bit12;
   assign lk_asid[0] = s0_asid;
   assign lk_asid[1] = s1_asid;

   // Scan from the top down so the lowest matching index is the one left in r.
   for (genvar p = 0; p < 2; p++) begin : g_port
      res_t r;
      always_comb begin
         r = '0;
         for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (e_q[i] && (g_q[i] || asid_q[i] == lk_asid[p]) &&
                va_match(vppn_q[i], ps_q[i], lk_vppn[p])) begin
               r.found = 1'b1;
               r.index = i[IDXW-1:0];
               r.ps    = ps_q[i];
               r.pg    = ((ps_q[i] == 6'd21) ? lk_vppn[p][8] : lk_b12[p]) ? pg1_q[i] : pg0_q[i];
            end
         end
      end
   end

   assign s0_found = g_port[0].r.found;
   assign s0_index = g_port[0].r.index;
   assign s0_ps    = g_port[0].r.ps;
   assign s0_ppn   = g_port[0].r.pg.ppn;
   assign s0_plv   = g_port[0].r.pg.plv;
   assign s0_mat   = g_port[0].r.pg.mat;
   assign s0_d     = g_port[0].r.pg.d;
   assign s0_v     = g_port[0].r.pg.v;
   assign s1_found = g_port[1].r.found;
   assign s1_index = g_port[1].r.index;
   assign s1_ps    = g_port[1].r.ps;
   assign s1_ppn   = g_port[1].r.pg.ppn;
   assign s1_plv   = g_port[1].r.pg.plv;
   assign s1_mat   = g_port[1].r.pg.mat;
   assign s1_d     = g_port[1].r.pg.d;
   assign s1_v     = g_port[1].r.pg.v;

   always_comb begin
      inv_hit = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         case (invtlb_op)
            5'd0, 5'd1: inv_hit[i] = 1'b1;
            5'd2:       inv_hit[i] = g_q[i];
            5'd3:       inv_hit[i] = !g_q[i];
            5'd4:       inv_hit[i] = !g_q[i] && asid_q[i] == invtlb_asid;
            5'd5:       inv_hit[i] = !g_q[i] && asid_q[i] == invtlb_asid &&
                                     va_match(vppn_q[i], ps_q[i], invtlb_vppn);
            5'd6:       inv_hit[i] = (g_q[i] || asid_q[i] == invtlb_asid) &&
                                     va_match(vppn_q[i], ps_q[i], invtlb_vppn);
            default:    inv_hit[i] = 1'b0;
         endcase
      end
   end

   // Write takes priority over invalidation on the same entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q <= '0;
      end else begin
         for (int i = 0; i < TLBNUM; i++) begin
            if (we && w_index == i[IDXW-1:0]) e_q[i] <= w_e;
            else if (invtlb_valid && inv_hit[i]) e_q[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we && !rst) begin
         vppn_q[w_index] <= w_vppn;
         ps_q[w_index]   <= w_ps;
         asid_q[w_index] <= w_asid;
         g_q[w_index]    <= w_g;
         pg0_q[w_index]  <= '{ppn: w_ppn0, plv: w_plv0, mat: w_mat0, d: w_d0, v: w_v0};
         pg1_q[w_index]  <= '{ppn: w_ppn1, plv: w_plv1, mat: w_mat1, d: w_d1, v: w_v1};
      end
   end

   assign r_e    = e_q[r_index];
   assign r_vppn = vppn_q[r_index];
   assign r_ps   = ps_q[r_index];
   assign r_asid = asid_q[r_index];
   assign r_g    = g_q[r_index];
   assign r_ppn0 = pg0_q[r_index].ppn;
   assign r_plv0 = pg0_q[r_index].plv;
   assign r_mat0 = pg0_q[r_index].mat;
   assign r_d0   = pg0_q[r_index].d;
   assign r_v0   = pg0_q[r_index].v;
   assign r_ppn1 = pg1_q[r_index].ppn;
   assign r_plv1 = pg1_q[r_index].plv;
   assign r_mat1 = pg1_q[r_index].mat;
   assign r_d1   = pg1_q[r_index].d;
   assign r_v1   = pg1_q[r_index].v;

endmodule

// File: tb/tb_tlb.sv
// tb/tb_tlb.sv - directed self-checking bench for tlb
// Inputs change 1ns after the rising edge; outputs are sampled 1ns after input changes.
module tb_tlb;
   logic clk = 1'b0;
   logic rst;
   logic [18:0] s0_vppn, s1_vppn, invtlb_vppn, w_vppn, r_vppn;
   logic s0_va_bit12, s1_va_bit12;
   logic [9:0] s0_asid, s1_asid, invtlb_asid, w_asid, r_asid;
   logic s0_found, s1_found, s0_d, s1_d, s0_v, s1_v;
   logic [3:0] s0_index, s1_index, w_index, r_index;
   logic [19:0] s0_ppn, s1_ppn, w_ppn0, w_ppn1, r_ppn0, r_ppn1;
   logic [5:0] s0_ps, s1_ps, w_ps, r_ps;
   logic [1:0] s0_plv, s1_plv, s0_mat, s1_mat, w_plv0, w_mat0, w_plv1, w_mat1;
   logic [1:0] r_plv0, r_mat0, r_plv1, r_mat1;
   logic invtlb_valid, we, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
   logic [4:0] invtlb_op;
   logic r_e, r_g, r_d0, r_v0, r_d1, r_v1;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   tlb #(.TLBNUM(16)) dut (
      .clk(clk), .rst(rst),
      .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
      .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps),
      .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
      .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
      .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps),
      .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
      .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
      .invtlb_vppn(invtlb_vppn),
      .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid),
      .w_g(w_g), .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
      .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
      .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
      .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
      .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Loads the w_* fields; odd-page D/PLV carry through for the first test entry.
   task automatic set_w(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                        input logic [5:0] ps, input logic [9:0] asid, input logic g,
                        input logic [19:0] ppn0, input logic [19:0] ppn1,
                        input logic d1, input logic [1:0] plv1);
      w_index = idx; w_e = e; w_vppn = vppn; w_ps = ps; w_asid = asid; w_g = g;
      w_ppn0 = ppn0; w_plv0 = 2'd0; w_mat0 = 2'd1; w_d0 = 1'b0; w_v0 = 1'b1;
      w_ppn1 = ppn1; w_plv1 = plv1; w_mat1 = 2'd1; w_d1 = d1; w_v1 = 1'b1;
   endtask

   task automatic wr(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                     input logic [5:0] ps, input logic [9:0] asid, input logic g,
                     input logic [19:0] ppn0, input logic [19:0] ppn1,
                     input logic d1, input logic [1:0] plv1);
      set_w(idx, e, vppn, ps, asid, g, ppn0, ppn1, d1, plv1);
      we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
      invtlb_valid = 1'b1; invtlb_op = op; invtlb_asid = asid; invtlb_vppn = vppn;
      tick();
      invtlb_valid = 1'b0;
   endtask

   task automatic rd_e(input logic [3:0] idx, input logic exp, input string tag);
      r_index = idx;
      #1;
      check(tag, {31'd0, r_e}, {31'd0, exp});
   endtask

   initial begin
      rst = 1'b1;
      s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0;
      s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
      invtlb_valid = 1'b0; invtlb_op = '0; invtlb_asid = '0; invtlb_vppn = '0;
      we = 1'b0; r_index = '0;
      set_w(4'd0, 1'b0, '0, 6'd12, '0, 1'b0, '0, '0, 1'b0, 2'd0);
      tick();
      s0_vppn = 19'h00010;
      #1;
      check("reset_s0_found", {31'd0, s0_found}, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("post_reset_s0_found", {31'd0, s0_found}, 32'd0);
      for (int i = 0; i < 16; i++) rd_e(i[3:0], 1'b0, "reset_r_e");

      // 4KB entry at idx 3
      wr(4'd3, 1'b1, 19'h00010, 6'd12, 10'd5, 1'b0, 20'h12345, 20'h23456, 1'b1, 2'd3);
      s1_vppn = 19'h00010; s1_va_bit12 = 1'b1; s1_asid = 10'd5;
      #1;
      check("s1_found_odd", {31'd0, s1_found}, 32'd1);
      check("s1_index_odd", {28'd0, s1_index}, 32'd3);
      check("s1_ppn_odd", {12'd0, s1_ppn}, 32'h23456);
      check("s1_d_odd", {31'd0, s1_d}, 32'd1);
      check("s1_plv_odd", {30'd0, s1_plv}, 32'd3);
      check("s1_ps_4k", {26'd0, s1_ps}, 32'd12);
      s1_va_bit12 = 1'b0;
      #1;
      check("s1_ppn_even", {12'd0, s1_ppn}, 32'h12345);
      check("s1_d_even", {31'd0, s1_d}, 32'd0);
      s1_asid = 10'd6;
      #1;
      check("s1_asid_miss", {31'd0, s1_found}, 32'd0);
      check("s1_miss_ppn_zero", {12'd0, s1_ppn}, 32'd0);
      check("s1_miss_index_zero", {28'd0, s1_index}, 32'd0);

      // 2MB global entry at idx 7
      wr(4'd7, 1'b1, 19'h40000, 6'd21, 10'd9, 1'b1, 20'h00400, 20'h00600, 1'b0, 2'd0);
      s1_vppn = 19'h401FF; s1_asid = 10'd2;
      #1;
      check("s1_2m_found", {31'd0, s1_found}, 32'd1);
      check("s1_2m_index", {28'd0, s1_index}, 32'd7);
      check("s1_2m_ppn", {12'd0, s1_ppn}, 32'h00600);
      check("s1_2m_ps", {26'd0, s1_ps}, 32'd21);
      s1_vppn = 19'h40000;
      #1;
      check("s1_2m_even_ppn", {12'd0, s1_ppn}, 32'h00400);
      s1_vppn = 19'h40200;
      #1;
      check("s1_2m_outside", {31'd0, s1_found}, 32'd0);

      inv(5'd5, 10'd5, 19'h00010);
      rd_e(4'd3, 1'b0, "op5_idx3_cleared");
      rd_e(4'd7, 1'b1, "op5_idx7_kept");
      inv(5'd2, 10'd0, 19'h0);
      rd_e(4'd7, 1'b0, "op2_idx7_cleared");
      wr(4'd3, 1'b1, 19'h00010, 6'd12, 10'd5, 1'b0, 20'h12345, 20'h23456, 1'b1, 2'd3);
      inv(5'd9, 10'd5, 19'h00010);
      rd_e(4'd3, 1'b1, "op9_no_change");

      // simultaneous write and invalidate-all
      wr(4'd2, 1'b0, 19'h11111, 6'd12, 10'd0, 1'b1, 20'h0, 20'h0, 1'b0, 2'd0);
      set_w(4'd2, 1'b1, 19'h22222, 6'd12, 10'd0, 1'b1, 20'h0ABCD, 20'h0, 1'b0, 2'd0);
      we = 1'b1;
      invtlb_valid = 1'b1; invtlb_op = 5'd0;
      r_index = 4'd2; s0_vppn = 19'h22222; s0_asid = 10'd1; s0_va_bit12 = 1'b0;
      #1;
      check("wr_cycle_old_vppn", {13'd0, r_vppn}, 32'h11111);
      check("wr_cycle_old_e", {31'd0, r_e}, 32'd0);
      check("wr_cycle_no_hit", {31'd0, s0_found}, 32'd0);
      tick();
      we = 1'b0; invtlb_valid = 1'b0;
      for (int i = 0; i < 16; i++) rd_e(i[3:0], (i == 2), "op0_plus_write_r_e");
      check("new_entry_hit", {31'd0, s0_found}, 32'd1);
      check("new_entry_ppn", {12'd0, s0_ppn}, 32'h0ABCD);

      // duplicate matches: lowest index wins
      wr(4'd9, 1'b1, 19'h03000, 6'd12, 10'd0, 1'b1, 20'h99999, 20'h0, 1'b0, 2'd0);
      wr(4'd4, 1'b1, 19'h03000, 6'd12, 10'd0, 1'b1, 20'h44444, 20'h0, 1'b0, 2'd0);
      s0_vppn = 19'h03000;
      #1;
      check("dup_found", {31'd0, s0_found}, 32'd1);
      check("dup_index", {28'd0, s0_index}, 32'd4);
      check("dup_ppn", {12'd0, s0_ppn}, 32'h44444);

      // async reset in the middle of a write cycle
      set_w(4'd5, 1'b1, 19'h05000, 6'd12, 10'd0, 1'b1, 20'h55555, 20'h0, 1'b0, 2'd0);
      we = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_found", {31'd0, s0_found}, 32'd0);
      rd_e(4'd4, 1'b0, "async_rst_r_e4");
      tick();
      we = 1'b0;
      rst = 1'b0;
      rd_e(4'd5, 1'b0, "rst_dropped_write");
      s0_vppn = 19'h05000;
      #1;
      check("rst_dropped_lookup", {31'd0, s0_found}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
